booth_product_accumulator: RTL and testbench
============================================

Name: booth_product_accumulator

Overview:
- Sequential stage directly downstream of the 8x8 Booth multiplier.
- Consumes the multiplier's 16-bit signed two's-complement products through a valid/ready handshake and accumulates them into frames of up to TERMS products (dot-product / MAC style).
- Presents each frame's signed sum, term count and saturation flag on a valid/ready output port.

Parameters:
- PROD_W, 16, product width; products are signed two's complement.
- ACC_W, 24, accumulator and output-sum width; must be >= PROD_W.
- TERMS, 4, maximum number of products per frame; must be >= 1.
- SATURATE, 1, 1 = clamp on signed overflow; 0 = wrap modulo 2^ACC_W.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  in_product/in_last are valid.
- in_ready  out  1  block can accept a product this cycle.
- in_product  in  PROD_W  signed product from the Booth multiplier.
- in_last  in  1  this product closes the frame early.
- out_valid  out  1  out_sum/out_count/out_sat are valid.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  ACC_W  signed frame sum.
- out_count  out  $clog2(TERMS+1)  number of products in the frame.
- out_sat  out  1  sticky: saturation (or wrap, if SATURATE=0) occurred in this frame.

Behaviour:
- Reset: rst is asynchronous and active-high.
  - State goes to ACC; accumulator, term counter and sat flag clear to 0.
  - out_valid=0, out_sum=0, out_count=0, out_sat=0.
  - in_ready is forced to 0 while rst is high.
- States: ACC and HOLD.
- in_ready = (state==ACC) && !rst. It is derived from the registered state only, never combinationally from out_ready.
- Accept: a product is accepted when in_valid && in_ready.
  - Sign-extend in_product to ACC_W+1 bits and add it to the sign-extended accumulator.
- Overflow check: if the ACC_W+1-bit result falls outside [-2^(ACC_W-1), 2^(ACC_W-1)-1]:
  - SATURATE=1: clamp to the nearest bound and set sat.
  - SATURATE=0: keep the low ACC_W bits and set sat.
  - Later terms add to the clamped or wrapped value.
- Frame close: the frame closes on an accepted product when term count == TERMS-1, or when in_last=1.
  - in_last on the TERMS-th term is redundant and harmless.
  - The next edge loads out_sum (including the closing term), out_count (= terms in the frame) and out_sat, sets out_valid=1 and moves to HOLD.
  - Latency: out_valid is high one cycle after the closing product is accepted.
- HOLD:
  - in_ready=0.
  - out_sum, out_count and out_sat stay stable while out_valid && !out_ready.
  - When out_valid && out_ready, the next edge clears out_valid, accumulator, counter and sat, and returns to ACC.
  - in_ready rises that same next cycle; there is no same-cycle bypass.
  - Maximum throughput is therefore one frame per (terms+1) cycles.
- out_sum/out_count/out_sat keep their last values after out_valid falls; they are don't-care for checking.
- in_valid in HOLD or during reset: no product is consumed, and upstream must hold its data.
- TERMS=1: every accepted product closes its own frame.
- No empty frames: a frame exists only once at least one product has been accepted.
- Reset mid-frame or mid-HOLD: partial sum and pending result are discarded; no result is emitted.
- Arithmetic is purely signed; the sum of an in-range frame is independent of product order.

Test Plan:
- TERMS=4, ACC_W=24; feed 15, 30, 975, 15375 back-to-back with out_ready=1 -> out_valid one cycle after the 4th accept; out_sum=16395, out_count=4, out_sat=0; in_ready low for exactly one cycle.
- Signed frame: 0xFFF1 (-15), 30, 0xFC31 (-975), 0 -> out_sum=0xFFFC40 (-960), out_count=4, out_sat=0.
- Early close: 100, then 200 with in_last=1 -> out_sum=300, out_count=2; the next frame starts from 0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid while in_valid=1 with product 7 -> out_sum stable, in_ready=0, nothing accepted; then out_ready=1 -> the next frame accepts 7 first.
- Saturation with ACC_W=17, SATURATE=1:
  - four x 32767 -> out_sum=65535, out_sat=1.
  - four x -32768 -> out_sum=-65536, out_sat=1.
  - With SATURATE=0, four x 32767 -> out_sum=-4 (131068 wrapped mod 2^17), out_sat=1.
- Reset mid-frame: accept 5 and 6, then pulse rst asynchronously between edges -> out_valid=0 and in_ready=0 immediately; after release, frame 1, 2, 3, 4 -> out_sum=10, out_count=4.

Source files
------------

// File: rtl/booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : booth_product_accumulator
// Purpose  : Accumulates signed Booth-multiplier products into frames of up
//            to TERMS terms and presents each frame's sum, term count and
//            overflow flag on a valid/ready output port.
// Revision : 1.0 - initial release
// ============================================================================
module booth_product_accumulator #(
    parameter int PROD_W   = 16,
    parameter int ACC_W    = 24,
    parameter int TERMS    = 4,
    parameter int SATURATE = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [PROD_W-1:0]            in_product,
    input  logic                         in_last,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ACC_W-1:0]             out_sum,
    output logic [$clog2(TERMS+1)-1:0]   out_count,
    output logic                         out_sat
);

    localparam int CNT_W = $clog2(TERMS + 1);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(TERMS - 1);
    localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);

    typedef enum logic [0:0] {
        ST_ACC  = 1'b0,
        ST_HOLD = 1'b1
    } state_t;

    state_t             r_state_q,     w_state_d;
    logic [ACC_W-1:0]   r_acc_q,       w_acc_d;
    logic [CNT_W-1:0]   r_cnt_q,       w_cnt_d;
    logic               r_sat_q,       w_sat_d;
    logic               r_out_valid_q, w_out_valid_d;
    logic [ACC_W-1:0]   r_out_sum_q,   w_out_sum_d;
    logic [CNT_W-1:0]   r_out_count_q, w_out_count_d;
    logic               r_out_sat_q,   w_out_sat_d;

    logic [ACC_W:0]     w_acc_ext;
    logic [ACC_W:0]     w_prod_ext;
    logic [ACC_W:0]     w_sum;
    logic               w_ovf;
    logic [ACC_W-1:0]   w_sum_fix;
    logic               w_accept;
    logic               w_close;

    // Ready comes only from the registered state so downstream stall never
    // forms a combinational path back to the multiplier.
    assign in_ready = (r_state_q == ST_ACC) && !rst;

    // One guard bit above the accumulator: overflow shows as the top two
    // bits of the widened sum disagreeing.
    assign w_acc_ext  = {r_acc_q[ACC_W-1], r_acc_q};
    assign w_prod_ext = {{(ACC_W + 1 - PROD_W){in_product[PROD_W-1]}}, in_product};
    assign w_sum      = w_acc_ext + w_prod_ext;
    assign w_ovf      = w_sum[ACC_W] ^ w_sum[ACC_W-1];

    generate
        if (SATURATE != 0) begin : g_saturate
            localparam logic [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
            localparam logic [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};
            // The guard bit holds the true sign, so it picks the bound to clamp to.
            assign w_sum_fix = !w_ovf ? w_sum[ACC_W-1:0]
                                      : (w_sum[ACC_W] ? c_acc_min : c_acc_max);
        end else begin : g_wrap
            assign w_sum_fix = w_sum[ACC_W-1:0];
        end
    endgenerate

    assign w_accept = in_valid && in_ready;
    assign w_close  = w_accept && (in_last || (r_cnt_q == c_cnt_last));

    // Next-state: accumulate in ACC, latch the result on the closing term,
    // then wait in HOLD until the consumer takes it.
    always_comb begin
        w_state_d     = r_state_q;
        w_acc_d       = r_acc_q;
        w_cnt_d       = r_cnt_q;
        w_sat_d       = r_sat_q;
        w_out_valid_d = r_out_valid_q;
        w_out_sum_d   = r_out_sum_q;
        w_out_count_d = r_out_count_q;
        w_out_sat_d   = r_out_sat_q;
        case (r_state_q)
            ST_ACC: begin
                if (w_accept) begin
                    w_acc_d = w_sum_fix;
                    w_cnt_d = r_cnt_q + c_cnt_one;
                    w_sat_d = r_sat_q | w_ovf;
                end
                if (w_close) begin
                    w_out_valid_d = 1'b1;
                    w_out_sum_d   = w_sum_fix;
                    w_out_count_d = r_cnt_q + c_cnt_one;
                    w_out_sat_d   = r_sat_q | w_ovf;
                    w_state_d     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (r_out_valid_q && out_ready) begin
                    w_out_valid_d = 1'b0;
                    w_acc_d       = '0;
                    w_cnt_d       = '0;
                    w_sat_d       = 1'b0;
                    w_state_d     = ST_ACC;
                end
            end
            default: w_state_d = ST_ACC;
        endcase
    end

    // State and result registers; reset discards any partial or pending frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q     <= ST_ACC;
            r_acc_q       <= '0;
            r_cnt_q       <= '0;
            r_sat_q       <= 1'b0;
            r_out_valid_q <= 1'b0;
            r_out_sum_q   <= '0;
            r_out_count_q <= '0;
            r_out_sat_q   <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_acc_q       <= w_acc_d;
            r_cnt_q       <= w_cnt_d;
            r_sat_q       <= w_sat_d;
            r_out_valid_q <= w_out_valid_d;
            r_out_sum_q   <= w_out_sum_d;
            r_out_count_q <= w_out_count_d;
            r_out_sat_q   <= w_out_sat_d;
        end
    end

    assign out_valid = r_out_valid_q;
    assign out_sum   = r_out_sum_q;
    assign out_count = r_out_count_q;
    assign out_sat   = r_out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_booth_product_accumulator.sv
`default_nettype none
// ============================================================================
// Module   : tb_booth_product_accumulator
// Purpose  : Scoreboard bench driving three accumulator instances (24-bit
//            saturating, 17-bit saturating, 17-bit wrapping) with identical
//            stimulus and checking them against an integer reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_booth_product_accumulator;

    localparam int TERMS = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [15:0] in_product = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b0;

    logic        rdy0, rdy1, rdy2;
    logic        vld0, vld1, vld2;
    logic [23:0] sum0;
    logic [16:0] sum1, sum2;
    logic [2:0]  cnt0, cnt1, cnt2;
    logic        sat0, sat1, sat2;

    int n_cmp = 0;
    int n_err = 0;

    always #10 clk = ~clk;

    booth_product_accumulator #(.PROD_W(16), .ACC_W(24), .TERMS(TERMS), .SATURATE(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy0), .in_product(in_product),
        .in_last(in_last), .out_valid(vld0), .out_ready(out_ready), .out_sum(sum0),
        .out_count(cnt0), .out_sat(sat0));

    booth_product_accumulator #(.PROD_W(16), .ACC_W(17), .TERMS(TERMS), .SATURATE(1)) u_dut_s17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy1), .in_product(in_product),
        .in_last(in_last), .out_valid(vld1), .out_ready(out_ready), .out_sum(sum1),
        .out_count(cnt1), .out_sat(sat1));

    booth_product_accumulator #(.PROD_W(16), .ACC_W(17), .TERMS(TERMS), .SATURATE(0)) u_dut_w17 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(rdy2), .in_product(in_product),
        .in_last(in_last), .out_valid(vld2), .out_ready(out_ready), .out_sum(sum2),
        .out_count(cnt2), .out_sat(sat2));

    // Expected frame result for all three instances.
    typedef struct {
        longint s0, s1, s2;
        bit     v0, v1, v2;
        int     cnt;
    } exp_t;

    exp_t exp_q[$];

    // Reference model state: exact integer sums per instance configuration.
    int     cfg_w[3] = '{24, 17, 17};
    bit     cfg_s[3] = '{1'b1, 1'b1, 1'b0};
    longint m_acc[3];
    bit     m_sat[3];
    int     m_cnt  = 0;
    bit     m_hold = 1'b0;

    task automatic chk(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
        end
    endtask

    // Bring a true integer sum back into a w-bit signed range, by clamping
    // or by modular wrap.
    function automatic longint fold(input longint s, input int w, input bit sat, output bit ovf);
        longint hi, lo, span, r;
        span = longint'(1) << w;
        hi   = (longint'(1) << (w - 1)) - 1;
        lo   = -(longint'(1) << (w - 1));
        ovf  = (s > hi) || (s < lo);
        if (!ovf) return s;
        if (sat) return (s > hi) ? hi : lo;
        r = (s - lo) % span;
        if (r < 0) r += span;
        return r + lo;
    endfunction

    task automatic model_clear();
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = 0;
            m_sat[k] = 1'b0;
        end
        m_cnt = 0;
    endtask

    task automatic model_accept(input logic [15:0] p, input bit l);
        exp_t e;
        bit   ovf;
        for (int k = 0; k < 3; k++) begin
            m_acc[k] = fold(m_acc[k] + longint'($signed(p)), cfg_w[k], cfg_s[k], ovf);
            m_sat[k] = m_sat[k] | ovf;
        end
        m_cnt++;
        if (l || m_cnt == TERMS) begin
            e.s0 = m_acc[0]; e.s1 = m_acc[1]; e.s2 = m_acc[2];
            e.v0 = m_sat[0]; e.v1 = m_sat[1]; e.v2 = m_sat[2];
            e.cnt = m_cnt;
            exp_q.push_back(e);
            model_clear();
            m_hold = 1'b1;
        end
    endtask

    // One clock cycle: apply inputs after the edge, check handshake levels
    // mid-cycle, and advance the model for what the next edge will do.
    task automatic drive(input bit v, input logic [15:0] p, input bit l, input bit r);
        @(posedge clk);
        #1;
        in_valid   = v;
        in_product = p;
        in_last    = l;
        out_ready  = r;
        @(negedge clk);
        chk("in_ready0", longint'(rdy0), longint'(!m_hold));
        chk("in_ready1", longint'(rdy1), longint'(!m_hold));
        chk("in_ready2", longint'(rdy2), longint'(!m_hold));
        chk("out_valid0", longint'(vld0), longint'(m_hold));
        chk("out_valid1", longint'(vld1), longint'(m_hold));
        chk("out_valid2", longint'(vld2), longint'(m_hold));
        if (!m_hold && v) model_accept(p, l);
        else if (m_hold && r) m_hold = 1'b0;
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #3 rst = 1'b1;
        #2;
        chk("rst_in_ready0", longint'(rdy0), 0);
        chk("rst_in_ready2", longint'(rdy2), 0);
        chk("rst_out_valid0", longint'(vld0), 0);
        chk("rst_out_valid1", longint'(vld1), 0);
        #2 rst = 1'b0;
        model_clear();
        m_hold = 1'b0;
        exp_q.delete();
        @(negedge clk);
    endtask

    task automatic frame4(input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [15:0] d);
        drive(1'b1, a, 1'b0, 1'b1);
        drive(1'b1, b, 1'b0, 1'b1);
        drive(1'b1, c, 1'b0, 1'b1);
        drive(1'b1, d, 1'b0, 1'b1);
    endtask

    // Monitor: every output handshake retires the oldest expected frame.
    always @(negedge clk) begin
        if (!rst && vld0 && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_frame actual=sum %0d required=no frame at %0t",
                         $signed(sum0), $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sum24",   longint'($signed(sum0)), e.s0);
                chk("sum17s",  longint'($signed(sum1)), e.s1);
                chk("sum17w",  longint'($signed(sum2)), e.s2);
                chk("sat24",   longint'(sat0), longint'(e.v0));
                chk("sat17s",  longint'(sat1), longint'(e.v1));
                chk("sat17w",  longint'(sat2), longint'(e.v2));
                chk("count24", longint'(cnt0), longint'(e.cnt));
                chk("count17s", longint'(cnt1), longint'(e.cnt));
                chk("count17w", longint'(cnt2), longint'(e.cnt));
            end
        end
    end

    initial begin
        logic [15:0] p;
        model_clear();
        @(negedge clk);
        @(negedge clk);
        chk("reset_out_valid", longint'(vld0), 0);
        chk("reset_out_sum",   longint'(sum0), 0);
        chk("reset_out_count", longint'(cnt0), 0);
        chk("reset_out_sat",   longint'(sat0), 0);
        chk("reset_in_ready",  longint'(rdy0), 0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Known frames, including a signed one and an early close.
        frame4(16'd15, 16'd30, 16'd975, 16'd15375);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        frame4(16'hFFF1, 16'd30, 16'hFC31, 16'd0);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        drive(1'b1, 16'd100, 1'b0, 1'b1);
        drive(1'b1, 16'd200, 1'b1, 1'b1);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Backpressure: the product 7 waits in HOLD and is the next frame's first term.
        frame4(16'd1, 16'd2, 16'd3, 16'd4);
        for (int i = 0; i < 5; i++) drive(1'b1, 16'd7, 1'b0, 1'b0);
        drive(1'b1, 16'd7, 1'b0, 1'b1);
        drive(1'b1, 16'd7, 1'b1, 1'b1);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Overflow frames for the 17-bit instances.
        frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        frame4(16'h8000, 16'h8000, 16'h8000, 16'h8000);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Reset mid-frame discards the partial sum.
        drive(1'b1, 16'd5, 1'b0, 1'b1);
        drive(1'b1, 16'd6, 1'b0, 1'b1);
        pulse_reset();
        frame4(16'd1, 16'd2, 16'd3, 16'd4);
        drive(1'b0, 16'd0, 1'b0, 1'b1);

        // Randomised traffic with random backpressure and occasional resets.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                pulse_reset();
            end else begin
                case ($urandom_range(0, 3))
                    0:       p = $urandom_range(0, 1) ? 16'h7FFF : 16'h8000;
                    1:       p = 16'($urandom_range(0, 255));
                    default: p = 16'($urandom);
                endcase
                drive($urandom_range(0, 3) != 0, p, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 2) != 0);
            end
        end

        // Drain with a bounded number of cycles.
        for (int i = 0; i < 20; i++) begin
            if (exp_q.size() != 0 || m_hold) drive(1'b0, 16'd0, 1'b0, 1'b1);
        end
        drive(1'b0, 16'd0, 1'b0, 1'b1);
        chk("drain_pending_frames", longint'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
